// File: rtl/i2c_target_if.sv
// MMIO bus bundle for the I2C target peripheral.
//   i_sel/i_we/i_re : select, write strobe, read strobe
//   i_addr          : register byte offset (bit0 ignored)
//   i_wdata         : write data
//   o_rdata/o_rdy   : combinational read data, always-ready
interface i2c_target_if;
  logic        i_sel;
  logic        i_we;
  logic        i_re;
  logic [3:0]  i_addr;
  logic [15:0] i_wdata;
  logic [15:0] o_rdata;
  logic        o_rdy;

  modport slave  (input i_sel, i_we, i_re, i_addr, i_wdata, output o_rdata, o_rdy);
  modport master (output i_sel, i_we, i_re, i_addr, i_wdata, input o_rdata, o_rdy);
endinterface

// File: rtl/i2c_target.sv
// Memory-mapped I2C target: matches a programmable 7-bit address, receives
// write bytes into RXDATA and serves read bytes from TXDATA. No clock stretching.
//   i_clk, i_rst      : system clock, async active-high reset
//   bus               : MMIO slave port (i2c_target_if)
//   i_scl, i_sda      : bus pin levels
//   o_sda_oe          : 1 pulls SDA low
//   o_irq             : IRQ_EN & IRQ_PEND
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | waiting for START (or disabled)
// ADDR      | shifting in the address byte
// ADDR_ACK  | driving address ACK during 9th clock
// RX        | shifting in a write byte
// RX_ACK    | driving ACK/NACK for a received byte
// TX        | driving a read byte MSB first
// TX_ACK    | sampling controller ACK/NACK
// WAIT_STOP | not ours or finished; SDA released until STOP/START
module i2c_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] RESET_ADDR  = 7'h42
) (
  input  logic        i_clk,
  input  logic        i_rst,
  i2c_target_if.slave bus,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_sda_oe,
  output logic        o_irq
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic [3:0]             r_bitcnt;
  logic [7:0]             r_shift;
  logic                   r_rw, r_hit, r_ack, r_sda_oe;
  logic                   r_en, r_irq_en, r_ack_data;
  logic                   r_rx_valid, r_rx_ovf, r_irq_pend, r_stop_seen, r_tx_under, r_tx_full;
  logic [6:0]             r_own;
  logic [7:0]             r_rxdata, r_txdata;

  logic       w_scl, w_sda, w_rise, w_fall, w_start, w_stop;
  logic       w_wr, w_rd, w_busy;
  logic [2:0] w_reg;
  logic [7:0] w_load_byte, w_status;
  logic       w_unused;

  assign w_scl   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda   = r_sda_sync[SYNC_STAGES-1];
  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;
  assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;

  assign w_reg = bus.i_addr[3:1];
  assign w_wr  = bus.i_sel & bus.i_we;
  assign w_rd  = bus.i_sel & bus.i_re;

  // An empty TX holding register reads as all-ones (bus idle level)
  assign w_load_byte = r_tx_full ? r_txdata : 8'hFF;
  assign w_busy      = (r_state != S_IDLE) && (r_state != S_WAIT_STOP);
  assign w_status    = {r_tx_full, r_tx_under, r_stop_seen, r_irq_pend,
                        r_rx_ovf, r_rx_valid, r_rw, w_busy};
  assign w_unused    = ^{bus.i_addr[0], bus.i_wdata[15:8]};

  always_comb begin
    bus.o_rdata = 16'h0000;
    if (w_rd) begin
      case (w_reg)
        3'd0:    bus.o_rdata = {13'b0, r_ack_data, r_irq_en, r_en};
        3'd1:    bus.o_rdata = {8'b0, w_status};
        3'd2:    bus.o_rdata = {9'b0, r_own};
        3'd3:    bus.o_rdata = {8'b0, r_rxdata};
        3'd4:    bus.o_rdata = {8'b0, r_txdata};
        default: bus.o_rdata = 16'h0000;
      endcase
    end
  end

  assign bus.o_rdy = 1'b1;
  assign o_sda_oe  = r_sda_oe;
  assign o_irq     = r_irq_en & r_irq_pend;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_scl_sync  <= '1;
      r_sda_sync  <= '1;
      r_scl_d     <= 1'b1;
      r_sda_d     <= 1'b1;
      r_bitcnt    <= 4'd0;
      r_shift     <= 8'h00;
      r_rw        <= 1'b0;
      r_hit       <= 1'b0;
      r_ack       <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_en        <= 1'b0;
      r_irq_en    <= 1'b0;
      r_ack_data  <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_ovf    <= 1'b0;
      r_irq_pend  <= 1'b0;
      r_stop_seen <= 1'b0;
      r_tx_under  <= 1'b0;
      r_tx_full   <= 1'b0;
      r_own       <= RESET_ADDR;
      r_rxdata    <= 8'h00;
      r_txdata    <= 8'h00;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;

      // MMIO clears come first so that hardware sets further down win
      if (w_wr) begin
        case (w_reg)
          3'd0: {r_ack_data, r_irq_en, r_en} <= bus.i_wdata[2:0];
          3'd1: begin
            if (bus.i_wdata[3]) r_rx_ovf    <= 1'b0;
            if (bus.i_wdata[4]) r_irq_pend  <= 1'b0;
            if (bus.i_wdata[5]) r_stop_seen <= 1'b0;
            if (bus.i_wdata[6]) r_tx_under  <= 1'b0;
          end
          3'd2:    r_own <= bus.i_wdata[6:0];
          default: ;
        endcase
      end
      if (w_rd && w_reg == 3'd3) r_rx_valid <= 1'b0;

      if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_hit    <= 1'b0;
        if (r_hit) begin
          r_stop_seen <= 1'b1;
          r_irq_pend  <= 1'b1;
        end
      end else if (!r_en) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_hit    <= 1'b0;
      end else if (w_start) begin
        r_state  <= S_ADDR;
        r_bitcnt <= 4'd0;
        r_sda_oe <= 1'b0;
        r_hit    <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_rise) begin
              r_shift  <= {r_shift[6:0], w_sda};
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_fall && r_bitcnt == 4'd8) begin
              r_bitcnt <= 4'd0;
              if (r_shift[7:1] == r_own) begin
                r_sda_oe <= 1'b1;
                r_rw     <= r_shift[0];
                r_hit    <= 1'b1;
                r_state  <= S_ADDR_ACK;
              end else begin
                r_state  <= S_WAIT_STOP;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_fall) begin
              if (!r_rw) begin
                r_sda_oe <= 1'b0;
                r_state  <= S_RX;
              end else begin
                r_shift    <= w_load_byte;
                r_sda_oe   <= ~w_load_byte[7];
                r_tx_full  <= 1'b0;
                r_irq_pend <= 1'b1;
                if (!r_tx_full) r_tx_under <= 1'b1;
                r_bitcnt   <= 4'd0;
                r_state    <= S_TX;
              end
            end
          end
          S_RX: begin
            if (w_rise) begin
              r_shift  <= {r_shift[6:0], w_sda};
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == 4'd7) begin
                if (r_rx_valid) begin
                  r_rx_ovf <= 1'b1;
                  r_ack    <= 1'b0;
                end else begin
                  r_rxdata   <= {r_shift[6:0], w_sda};
                  r_rx_valid <= 1'b1;
                  r_irq_pend <= 1'b1;
                  r_ack      <= r_ack_data;
                end
              end
            end else if (w_fall && r_bitcnt == 4'd8) begin
              r_sda_oe <= r_ack;
              r_bitcnt <= 4'd0;
              r_state  <= S_RX_ACK;
            end
          end
          S_RX_ACK: begin
            if (w_fall) begin
              r_sda_oe <= 1'b0;
              r_state  <= r_ack ? S_RX : S_WAIT_STOP;
            end
          end
          S_TX: begin
            if (w_fall) begin
              if (r_bitcnt == 4'd7) begin
                r_sda_oe <= 1'b0;
                r_state  <= S_TX_ACK;
              end else begin
                r_sda_oe <= ~r_shift[6];
                r_shift  <= {r_shift[6:0], 1'b0};
                r_bitcnt <= r_bitcnt + 4'd1;
              end
            end
          end
          S_TX_ACK: begin
            if (w_rise) begin
              if (w_sda) r_state <= S_WAIT_STOP;
            end else if (w_fall) begin
              r_shift    <= w_load_byte;
              r_sda_oe   <= ~w_load_byte[7];
              r_tx_full  <= 1'b0;
              r_irq_pend <= 1'b1;
              if (!r_tx_full) r_tx_under <= 1'b1;
              r_bitcnt   <= 4'd0;
              r_state    <= S_TX;
            end
          end
          default: ;
        endcase
      end

      // After the FSM so a TXDATA write re-arms TX_FULL even on a load cycle
      if (w_wr && w_reg == 3'd4) begin
        r_txdata  <= bus.i_wdata[7:0];
        r_tx_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;
  localparam int H = 12;

  logic clk, rst, scl, sda_rel, sda_oe, irq, sda_line;
  logic chk_oe, chk_irq, exp_oe;
  int   n_checks, n_fails;

  // transaction-level model of the target's register state
  logic [2:0] m_ctrl;
  logic [6:0] m_own;
  logic [7:0] m_rx, m_tx;
  logic       m_rxv, m_ovf, m_pend, m_stop, m_under, m_txf, m_rw, m_hit;

  i2c_target_if bus_if ();

  assign sda_line = sda_rel & ~sda_oe;

  i2c_target #(.SYNC_STAGES(2), .RESET_ADDR(7'h42)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus_if.slave),
    .i_scl(scl), .i_sda(sda_line), .o_sda_oe(sda_oe), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      if (n_fails < 40) $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_oe)  chk("sda_oe", {15'b0, sda_oe}, {15'b0, exp_oe});
    if (chk_irq) chk("irq", {15'b0, irq}, {15'b0, m_ctrl[1] & m_pend});
  end

  task automatic m_reset();
    m_ctrl = 3'd0; m_own = 7'h42; m_rx = 8'h00; m_tx = 8'h00;
    m_rxv = 0; m_ovf = 0; m_pend = 0; m_stop = 0; m_under = 0; m_txf = 0; m_rw = 0; m_hit = 0;
  endtask

  function automatic logic [15:0] m_reg(input logic [3:0] a);
    case (a[3:1])
      3'd0:    return {13'b0, m_ctrl};
      3'd1:    return {8'b0, m_txf, m_under, m_stop, m_pend, m_ovf, m_rxv, m_rw, 1'b0};
      3'd2:    return {9'b0, m_own};
      3'd3:    return {8'b0, m_rx};
      3'd4:    return {8'b0, m_tx};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic mm_wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    bus_if.i_sel = 1; bus_if.i_we = 1; bus_if.i_addr = a; bus_if.i_wdata = d;
    case (a[3:1])
      3'd0: m_ctrl = d[2:0];
      3'd1: begin
        if (d[3]) m_ovf = 0;
        if (d[4]) m_pend = 0;
        if (d[5]) m_stop = 0;
        if (d[6]) m_under = 0;
      end
      3'd2: m_own = d[6:0];
      3'd4: begin m_tx = d[7:0]; m_txf = 1; end
      default: ;
    endcase
    @(negedge clk);
    bus_if.i_sel = 0; bus_if.i_we = 0;
  endtask

  task automatic mm_rd(input logic [3:0] a, input logic [15:0] exp, input string nm);
    @(negedge clk);
    bus_if.i_sel = 1; bus_if.i_re = 1; bus_if.i_addr = a;
    #1 chk(nm, bus_if.o_rdata, exp);
    @(negedge clk);
    bus_if.i_sel = 0; bus_if.i_re = 0;
    if (a[3:1] == 3'd3) m_rxv = 0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one SCL clock starting and ending with SCL low; checks oe over the high phase
  task automatic bit_cycle(input logic drv, input logic exp);
    wait_n(3); sda_rel = drv;
    wait_n(H - 3); scl = 1;
    wait_n(5); exp_oe = exp; chk_oe = 1;
    wait_n(H - 6); chk_oe = 0;
    wait_n(1); scl = 0;
  endtask

  task automatic i2c_start();
    wait_n(3); sda_rel = 1;
    wait_n(H); scl = 1;
    wait_n(H); sda_rel = 0;
    wait_n(H); scl = 0;
    m_hit = 0;
  endtask

  task automatic i2c_stop();
    wait_n(3); sda_rel = 0;
    wait_n(H); scl = 1;
    wait_n(H); sda_rel = 1;
    wait_n(H);
    if (m_hit) begin m_stop = 1; m_pend = 1; end
    m_hit = 0;
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], 1'b0);
    bit_cycle(1'b1, ack);
  endtask

  task automatic rd_byte(input logic [7:0] b, input logic mack);
    for (int i = 7; i >= 0; i--) bit_cycle(1'b1, ~b[i]);
    bit_cycle(~mack, 1'b0);
  endtask

  task automatic do_addr(input logic [7:0] a);
    logic ack;
    ack = m_ctrl[0] && (a[7:1] == m_own);
    if (ack) begin m_rw = a[0]; m_hit = 1; end
    wr_byte(a, ack);
  endtask

  task automatic do_wr(input logic [7:0] b);
    logic ack;
    if (m_rxv) begin
      m_ovf = 1; ack = 0;
    end else begin
      m_rx = b; m_rxv = 1; m_pend = 1; ack = m_ctrl[2];
    end
    wr_byte(b, ack);
  endtask

  task automatic do_rd(input logic mack);
    logic [7:0] b;
    b = m_txf ? m_tx : 8'hFF;
    if (!m_txf) m_under = 1;
    m_txf = 0; m_pend = 1;
    rd_byte(b, mack);
  endtask

  task automatic rd_all_reset(input string tag);
    mm_rd(4'h0, 16'h0000, {tag, "_ctrl"});
    mm_rd(4'h2, 16'h0000, {tag, "_status"});
    mm_rd(4'h4, 16'h0042, {tag, "_own"});
    mm_rd(4'h6, 16'h0000, {tag, "_rxdata"});
    mm_rd(4'h8, 16'h0000, {tag, "_txdata"});
  endtask

  initial begin
    logic [7:0] b;
    clk = 0; rst = 1; scl = 1; sda_rel = 1;
    bus_if.i_sel = 0; bus_if.i_we = 0; bus_if.i_re = 0; bus_if.i_addr = 4'h0; bus_if.i_wdata = 16'h0;
    chk_oe = 0; chk_irq = 0; exp_oe = 0; n_checks = 0; n_fails = 0;
    m_reset();
    wait_n(3); rst = 0; wait_n(2);

    chk("rst_oe", {15'b0, sda_oe}, 16'h0000);
    chk("rst_irq", {15'b0, irq}, 16'h0000);
    chk("rst_rdy", {15'b0, bus_if.o_rdy}, 16'h0001);
    chk("rdata_unsel", bus_if.o_rdata, 16'h0000);
    rd_all_reset("rst");
    chk_irq = 1;

    // write addr 0x84 + data 0x3C
    mm_wr(4'h0, 16'h0007);
    chk_irq = 0; i2c_start(); do_addr(8'h84); do_wr(8'h3C); i2c_stop(); chk_irq = 1;
    mm_rd(4'h2, m_reg(4'h2), "t1_status");
    mm_rd(4'h2, 16'h0034, "t1_status_lit");
    chk("t1_irq_lit", {15'b0, irq}, 16'h0001);
    mm_rd(4'h6, 16'h003C, "t1_rxdata");
    mm_rd(4'h2, m_reg(4'h2), "t1_status_after_rd");
    mm_wr(4'h2, 16'h0078);
    mm_rd(4'h2, 16'h0000, "t1_status_clr");

    // foreign address 0x86 (0x43)
    chk_irq = 0; i2c_start(); do_addr(8'h86); i2c_stop(); chk_irq = 1;
    mm_rd(4'h2, m_reg(4'h2), "t2_status");
    mm_rd(4'h2, 16'h0000, "t2_status_lit");

    // single-byte read of 0xA5, then underrun read
    mm_wr(4'h8, 16'h00A5);
    mm_rd(4'h2, 16'h0080, "t3_txfull_lit");
    chk_irq = 0; i2c_start(); do_addr(8'h85); do_rd(1'b0); i2c_stop(); chk_irq = 1;
    mm_rd(4'h2, m_reg(4'h2), "t3_status");
    mm_rd(4'h2, 16'h0032, "t3_status_lit");
    mm_wr(4'h2, 16'h0078);
    chk_irq = 0; i2c_start(); do_addr(8'h85); do_rd(1'b0); i2c_stop(); chk_irq = 1;
    mm_rd(4'h2, m_reg(4'h2), "t3_under_status");
    mm_rd(4'h2, 16'h0072, "t3_under_lit");
    mm_wr(4'h2, 16'h0078);

    // two-byte write without draining RXDATA
    chk_irq = 0; i2c_start(); do_addr(8'h84); do_wr(8'h11); do_wr(8'h22); i2c_stop(); chk_irq = 1;
    mm_rd(4'h2, m_reg(4'h2), "t4_status");
    mm_rd(4'h2, 16'h003C, "t4_status_lit");
    mm_wr(4'h2, 16'h0018);
    mm_rd(4'h2, 16'h0024, "t4_w1c_lit");
    mm_rd(4'h6, m_reg(4'h6), "t4_rxdata");
    mm_rd(4'h2, m_reg(4'h2), "t4_status_drained");
    mm_wr(4'h2, 16'h0078);

    // write then repeated START into a read
    mm_wr(4'h8, 16'h005A);
    chk_irq = 0;
    i2c_start(); do_addr(8'h84); do_wr(8'h01);
    i2c_start(); do_addr(8'h85); do_rd(1'b0); i2c_stop();
    chk_irq = 1;
    mm_rd(4'h2, m_reg(4'h2), "t5_status");
    mm_rd(4'h2, 16'h0036, "t5_status_lit");
    mm_rd(4'h6, 16'h0001, "t5_rxdata_lit");
    mm_wr(4'h2, 16'h0078);

    // reset while the target is driving the address ACK
    chk_irq = 0;
    i2c_start();
    b = 8'h84;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], 1'b0);
    wait_n(3); sda_rel = 1;
    wait_n(H - 3); scl = 1;
    wait_n(5);
    chk("t6_ack_before_rst", {15'b0, sda_oe}, 16'h0001);
    #2 rst = 1;
    #1 chk("t6_oe_async", {15'b0, sda_oe}, 16'h0000);
    @(negedge clk); rst = 0; m_reset();
    wait_n(4);
    rd_all_reset("t6");
    chk_irq = 1;
    mm_wr(4'h0, 16'h0007);
    chk_irq = 0; i2c_start(); do_addr(8'h84); do_wr(8'h55); i2c_stop(); chk_irq = 1;
    mm_rd(4'h6, 16'h0055, "t6_rxdata_lit");
    mm_rd(4'h2, m_reg(4'h2), "t6_status");
    wait_n(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
